// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision field definitions and constants for the FP datapath blocks.
package fpu_pkg;
  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int WORD_W  = SIGN_W + EXP_W + MANT_W;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;
endpackage

// File: rtl/fsub_lzc.sv
// Combinational leading-zero counter over a 24-bit significand; returns 24 for an all-zero input.
module fsub_lzc
  import fpu_pkg::*;
(
  input  logic [MANT_W:0] a,
  output logic [4:0]      cnt
);
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i <= MANT_W; i++) begin
      if (a[i]) cnt = 5'(MANT_W - i);
    end
  end
endmodule

// File: rtl/fsub.sv
// Single-precision subtractor y = x1 - x2, two-stage pipeline, flush-to-zero, RNE rounding.
module fsub
  import fpu_pkg::*;
(
  input  logic [WORD_W-1:0] x1,
  input  logic [WORD_W-1:0] x2,
  output logic [WORD_W-1:0] y,
  output logic              ovf,
  input  logic              clk,
  input  logic              rstn
);
  localparam logic [EXP_W-1:0]  EXP_INF = EXP_W'(EXP_MAX);
  localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

  // n holds the normalized significand below the hidden bit plus guard/round/sticky.
  function automatic logic [23:0] rne(input logic [25:0] n);
    logic        up;
    logic [22:0] frac;
    up   = n[2] & (n[3] | n[1] | n[0]);
    frac = n[25:3] + 23'(up);
    return {up & (&n[25:3]), frac};
  endfunction

  function automatic logic [32:0] sat_pack(input logic sign, input logic signed [9:0] e,
                                           input logic [22:0] frac, input logic zero);
    if (zero || e < 10'sd1) return '0;
    if (e >= EXP_TOP) return {1'b1, sign, EXP_INF, 23'b0};
    return {1'b0, sign, e[7:0], frac};
  endfunction

  fp32_t       a, b;
  logic        b_sign, a_zero, a_inf, b_zero, b_inf, swap, sub, sticky;
  logic [7:0]  e_diff;
  logic [23:0] sig_big, sig_small;
  logic [26:0] small_ext, shifted, aligned;

  logic        sign_p1_d, sign_p1_q;
  logic [7:0]  exp_p1_d, exp_p1_q;
  logic [27:0] sum_p1_d, sum_p1_q;
  logic        spec_p1_d, spec_p1_q;
  logic [31:0] spec_y_p1_d, spec_y_p1_q;

  // Stage 1: special-operand decode, compare/swap, align, add/subtract
  always_comb begin
    a         = x1;
    b         = x2;
    b_sign    = ~b.sign;
    a_zero    = (a.exp == '0);
    b_zero    = (b.exp == '0);
    a_inf     = (a.exp == EXP_INF);
    b_inf     = (b.exp == EXP_INF);
    swap      = {b.exp, b.mant} > {a.exp, a.mant};
    e_diff    = swap ? (b.exp - a.exp) : (a.exp - b.exp);
    sig_big   = {1'b1, swap ? b.mant : a.mant};
    sig_small = {1'b1, swap ? a.mant : b.mant};
    small_ext = {sig_small, 3'b000};
    shifted   = small_ext >> e_diff;
    if (e_diff >= 8'd27) sticky = 1'b1;
    else                 sticky = |(small_ext & ((27'd1 << e_diff[4:0]) - 27'd1));
    aligned   = {shifted[26:1], shifted[0] | sticky};
    sub       = a.sign ^ b_sign;
    sum_p1_d  = sub ? ({1'b0, sig_big, 3'b000} - {1'b0, aligned})
                    : ({1'b0, sig_big, 3'b000} + {1'b0, aligned});
    sign_p1_d = swap ? b_sign : a.sign;
    exp_p1_d  = swap ? b.exp : a.exp;

    spec_p1_d   = a_inf | b_inf | a_zero | b_zero;
    spec_y_p1_d = '0;
    if (a_inf && b_inf)   spec_y_p1_d = (a.sign != b_sign) ? QNAN : {a.sign, EXP_INF, 23'b0};
    else if (a_inf)       spec_y_p1_d = {a.sign, EXP_INF, 23'b0};
    else if (b_inf)       spec_y_p1_d = {b_sign, EXP_INF, 23'b0};
    else if (a_zero && b_zero) spec_y_p1_d = {a.sign & b_sign, 31'b0};
    else if (a_zero)      spec_y_p1_d = {b_sign, x2[30:0]};
    else if (b_zero)      spec_y_p1_d = x1;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sign_p1_q   <= 1'b0;
      exp_p1_q    <= '0;
      sum_p1_q    <= '0;
      spec_p1_q   <= 1'b0;
      spec_y_p1_q <= '0;
    end else begin
      sign_p1_q   <= sign_p1_d;
      exp_p1_q    <= exp_p1_d;
      sum_p1_q    <= sum_p1_d;
      spec_p1_q   <= spec_p1_d;
      spec_y_p1_q <= spec_y_p1_d;
    end
  end

  logic               carry;
  logic [4:0]         lz, shamt;
  logic [26:0]        pre_norm, norm;
  logic signed [9:0]  exp_n, exp_r;
  logic [23:0]        rnd;
  logic [32:0]        packed_res;
  logic [31:0]        y_p2_d, y_p2_q;
  logic               ovf_p2_d, ovf_p2_q;

  fsub_lzc u_lzc (
    .a   (sum_p1_q[26:3]),
    .cnt (lz)
  );

  // Stage 2: normalize (carry right-shift or LZC left-shift), round, pack, overflow
  always_comb begin
    carry      = sum_p1_q[27];
    pre_norm   = carry ? {sum_p1_q[27:2], sum_p1_q[1] | sum_p1_q[0]} : sum_p1_q[26:0];
    shamt      = carry ? 5'd0 : lz;
    norm       = pre_norm << shamt;
    exp_n      = $signed({2'b00, exp_p1_q}) + $signed({9'd0, carry}) - $signed({5'd0, shamt});
    rnd        = rne(norm[25:0]);
    exp_r      = exp_n + $signed({9'd0, rnd[23]});
    packed_res = sat_pack(sign_p1_q, exp_r, rnd[22:0], ~norm[26]);
    y_p2_d     = spec_p1_q ? spec_y_p1_q : packed_res[31:0];
    ovf_p2_d   = spec_p1_q ? 1'b0 : packed_res[32];
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      y_p2_q   <= '0;
      ovf_p2_q <= 1'b0;
    end else begin
      y_p2_q   <= y_p2_d;
      ovf_p2_q <= ovf_p2_d;
    end
  end

  assign y   = y_p2_q;
  assign ovf = ovf_p2_q;
endmodule

// File: tb/tb_fsub.sv
// Scoreboard bench for fsub: expected results are queued at issue and compared two edges later.
module tb_fsub;
  import fpu_pkg::*;

  logic [31:0] x1, x2, y;
  logic        ovf, clk, rstn;

  fsub dut (
    .x1   (x1),
    .x2   (x2),
    .y    (y),
    .ovf  (ovf),
    .clk  (clk),
    .rstn (rstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          tol;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want,
                     input int tol);
    longint d;
    n_cmp++;
    d = longint'(got) - longint'(want);
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", tag, got, want, tol);
    end
  endtask

  function automatic real to_real(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'h00)      d = {v[31], 63'b0};
    else if (v[30:23] == 8'hFF) d = {v[31], 11'h7FF, 52'b0};
    else                        d = {v[31], 11'(int'(v[30:23]) - BIAS + 1023), v[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Reference: exact-ish subtraction in double precision, then RNE down to single.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ey, output logic eovf);
    real         r;
    logic [63:0] d;
    int          e;
    logic [23:0] m;
    logic        up, fin;
    fin  = (a[30:23] != 8'hFF) && (b[30:23] != 8'hFF);
    r    = to_real(a) - to_real(b);
    d    = $realtobits(r);
    eovf = 1'b0;
    if (d[62:52] == 11'h7FF) ey = (d[51:0] != 0) ? QNAN : {d[63], 8'hFF, 23'b0};
    else if (d[62:0] == 0)   ey = {d[63], 31'b0};
    else begin
      e  = int'(d[62:52]) - 1023 + BIAS;
      m  = {1'b1, d[51:29]};
      up = d[28] & ((d[27:0] != 0) | m[0]);
      if (up) begin
        if (&m) begin m = 24'h800000; e++; end
        else m = m + 24'd1;
      end
      if (e < 1) ey = '0;
      else if (e >= EXP_MAX) begin ey = {d[63], 8'hFF, 23'b0}; eovf = fin; end
      else ey = {d[63], e[7:0], m[22:0]};
    end
  endtask

  task automatic check_front();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.tag, ".y"}, y, e.y, e.tol);
    chk({e.tag, ".ovf"}, {31'b0, ovf}, {31'b0, e.ovf}, 0);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    if (sb_q.size() == 2) check_front();
    x1 = a;
    x2 = b;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step_dir(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey,
                          input logic eovf, input string tag);
    exp_t e;
    e.y = ey; e.ovf = eovf; e.tol = 0; e.tag = tag;
    step(a, b, e);
  endtask

  task automatic step_rnd(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(a, b, e.y, e.ovf);
    e.tol = 1;
    e.tag = $sformatf("rnd %h-%h", a, b);
    step(a, b, e);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[22:0] = '0;
    return v;
  endfunction

  task automatic rand_burst(input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = rand_fp();
      if ($urandom_range(0, 3) == 0 && a[30:23] > 8'd2 && a[30:23] < 8'd250) begin
        b = a;
        b[30:23] = a[30:23] - 8'd1 + 8'($urandom_range(0, 2));
        b[9:0]   = 10'($urandom);
      end else begin
        b = rand_fp();
      end
      step_rnd(a, b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b1;
    x1    = 32'h3F80_0000;
    x2    = 32'h4000_0000;
    repeat (3) @(negedge clk);
    chk("rst.y", y, 32'h0, 0);
    chk("rst.ovf", {31'b0, ovf}, 32'h0, 0);
    rstn = 1'b0;

    step_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "three_minus_one");
    chk("first_bubble.y", y, 32'h0, 0);
    step_dir(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, "equal");
    step_dir(32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000, 1'b0, "cancel");
    step_dir(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, "ovf_add");
    step_dir(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, "inf_minus_fin");
    step_dir(32'h3F80_0000, 32'h0040_0000, 32'h3F80_0000, 1'b0, "denorm_flush");
    step_dir(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b0, "zero_minus_x");
    step_dir(32'h4049_0FDB, 32'h8000_0000, 32'h4049_0FDB, 1'b0, "x_minus_zero");
    step_dir(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, "inf_minus_inf");
    step_dir(32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, "fin_minus_inf");
    step_dir(32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, "ninf_minus_inf");
    step_dir(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 1'b0, "underflow");
    step_dir(32'h3FC0_0000, 32'hBF80_0000, 32'h4020_0000, 1'b0, "mixed_sign");
    step_dir(32'h4B80_0000, 32'h3F80_0000, 32'h4B7F_FFFF, 1'b0, "borrow_norm");
    step_dir(32'h4B80_0000, 32'hBF80_0000, 32'h4B80_0000, 1'b0, "tie_even_down");
    step_dir(32'h4B80_0001, 32'hBF80_0000, 32'h4B80_0002, 1'b0, "tie_even_up");
    step_dir(32'h7F7F_FFFF, 32'hF300_0000, 32'h7F80_0000, 1'b1, "round_ovf");

    rand_burst(3000);

    step_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "pre_rst_a");
    step_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "pre_rst_b");
    step_dir(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "pre_rst_c");
    #2 rstn = 1'b1;
    #1;
    chk("midrst.y", y, 32'h0, 0);
    chk("midrst.ovf", {31'b0, ovf}, 32'h0, 0);
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b0;
    step_dir(32'h3FC0_0000, 32'hBF80_0000, 32'h4020_0000, 1'b0, "post_rst");
    chk("post_rst_bubble.y", y, 32'h0, 0);
    chk("post_rst_bubble.ovf", {31'b0, ovf}, 32'h0, 0);

    rand_burst(200);

    while (sb_q.size() > 0) begin
      check_front();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
